// File: rtl/booth_product_accumulator.sv
// rtl/booth_product_accumulator.sv - edge-captured signed product accumulator with valid/ready sum output
module booth_product_accumulator #(
    parameter int NUM_TERMS = 4,
    parameter int ACC_WIDTH = 20
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 data_valid_i,
    input  logic [15:0]          product_i,
    input  logic                 sum_ready_i,
    output logic                 sum_valid_o,
    output logic [ACC_WIDTH-1:0] sum_o,
    output logic                 overflow_o,
    output logic                 drop_o,
    output logic [7:0]           term_count_o,
    output logic                 busy_o
);

    typedef enum logic {ST_ACCUM, ST_OUTPUT} state_t;

    state_t               state_q, state_d;
    logic                 prev_valid_q, prev_valid_d;
    logic                 pending_valid_q, pending_valid_d;
    logic [15:0]          pending_data_q, pending_data_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]           term_count_q, term_count_d;
    logic                 ovf_acc_q, ovf_acc_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic                 sum_valid_q, sum_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 drop_q, drop_d;

    logic                 capture;
    logic [15:0]          term_prod;
    logic [ACC_WIDTH-1:0] term_ext;
    logic [ACC_WIDTH-1:0] add_res;
    logic                 add_ovf;

    // A rising data-valid level is a new product; a level high out of reset is ignored.
    assign capture   = data_valid_i & ~prev_valid_q;
    // The pending entry always has precedence over a fresh capture as the next term.
    assign term_prod = pending_valid_q ? pending_data_q : product_i;

    // Sign-extend the selected term and form the wrapping sum with its signed overflow flag.
    always_comb begin
        for (int i = 0; i < ACC_WIDTH; i++) begin
            term_ext[i] = (i < 16) ? term_prod[i] : term_prod[15];
        end
        add_res = acc_q + term_ext;
        add_ovf = (acc_q[ACC_WIDTH-1] == term_ext[ACC_WIDTH-1]) &&
                  (add_res[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    end

    // Next-state logic: term selection, accumulation, sum presentation and back-pressure buffering.
    always_comb begin
        state_d         = state_q;
        prev_valid_d    = data_valid_i;
        pending_valid_d = pending_valid_q;
        pending_data_d  = pending_data_q;
        acc_d           = acc_q;
        term_count_d    = term_count_q;
        ovf_acc_d       = ovf_acc_q;
        sum_d           = sum_q;
        sum_valid_d     = sum_valid_q;
        overflow_d      = overflow_q;
        drop_d          = drop_q;

        if (clear_i) begin
            state_d         = ST_ACCUM;
            pending_valid_d = 1'b0;
            acc_d           = '0;
            term_count_d    = 8'd0;
            ovf_acc_d       = 1'b0;
            sum_valid_d     = 1'b0;
            overflow_d      = 1'b0;
            drop_d          = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (pending_valid_q) begin
                        // Pending is freed this cycle, so a simultaneous capture refills it.
                        pending_valid_d = capture;
                        if (capture) begin
                            pending_data_d = product_i;
                        end
                    end
                    if (pending_valid_q || capture) begin
                        acc_d        = add_res;
                        term_count_d = term_count_q + 8'd1;
                        ovf_acc_d    = ovf_acc_q | add_ovf;
                        if (term_count_q == 8'(NUM_TERMS - 1)) begin
                            sum_d       = add_res;
                            overflow_d  = ovf_acc_q | add_ovf;
                            sum_valid_d = 1'b1;
                            state_d     = ST_OUTPUT;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (capture) begin
                        if (!pending_valid_q) begin
                            pending_valid_d = 1'b1;
                            pending_data_d  = product_i;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                    if (sum_valid_q && sum_ready_i) begin
                        sum_valid_d  = 1'b0;
                        acc_d        = '0;
                        term_count_d = 8'd0;
                        ovf_acc_d    = 1'b0;
                        state_d      = ST_ACCUM;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    // State registers with synchronous reset; prev_valid resets high to mask an already-high level.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= ST_ACCUM;
            prev_valid_q    <= 1'b1;
            pending_valid_q <= 1'b0;
            pending_data_q  <= 16'd0;
            acc_q           <= '0;
            term_count_q    <= 8'd0;
            ovf_acc_q       <= 1'b0;
            sum_q           <= '0;
            sum_valid_q     <= 1'b0;
            overflow_q      <= 1'b0;
            drop_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            prev_valid_q    <= prev_valid_d;
            pending_valid_q <= pending_valid_d;
            pending_data_q  <= pending_data_d;
            acc_q           <= acc_d;
            term_count_q    <= term_count_d;
            ovf_acc_q       <= ovf_acc_d;
            sum_q           <= sum_d;
            sum_valid_q     <= sum_valid_d;
            overflow_q      <= overflow_d;
            drop_q          <= drop_d;
        end
    end

    assign sum_valid_o  = sum_valid_q;
    assign sum_o        = sum_q;
    assign overflow_o   = overflow_q;
    assign drop_o       = drop_q;
    assign term_count_o = term_count_q;
    assign busy_o       = (term_count_q != 8'd0) | pending_valid_q | (state_q == ST_OUTPUT);

endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb/tb_booth_product_accumulator.sv - directed-vector bench for booth_product_accumulator
module tb_booth_product_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        dv = 1'b0;
    logic [15:0] prod = 16'd0;
    logic        ready = 1'b1;

    logic        a_valid, a_ovf, a_drop, a_busy;
    logic [19:0] a_sum;
    logic [7:0]  a_cnt;
    logic        b_valid, b_ovf, b_drop, b_busy;
    logic [15:0] b_sum;
    logic [7:0]  b_cnt;
    logic        c_valid, c_ovf, c_drop, c_busy;
    logic [19:0] c_sum;
    logic [7:0]  c_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    booth_product_accumulator #(.NUM_TERMS(4), .ACC_WIDTH(20)) dut (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .data_valid_i(dv),
        .product_i(prod), .sum_ready_i(ready), .sum_valid_o(a_valid), .sum_o(a_sum),
        .overflow_o(a_ovf), .drop_o(a_drop), .term_count_o(a_cnt), .busy_o(a_busy));

    booth_product_accumulator #(.NUM_TERMS(4), .ACC_WIDTH(16)) dut16 (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .data_valid_i(dv),
        .product_i(prod), .sum_ready_i(ready), .sum_valid_o(b_valid), .sum_o(b_sum),
        .overflow_o(b_ovf), .drop_o(b_drop), .term_count_o(b_cnt), .busy_o(b_busy));

    booth_product_accumulator #(.NUM_TERMS(1), .ACC_WIDTH(20)) dut1 (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .data_valid_i(dv),
        .product_i(prod), .sum_ready_i(ready), .sum_valid_o(c_valid), .sum_o(c_sum),
        .overflow_o(c_ovf), .drop_o(c_drop), .term_count_o(c_cnt), .busy_o(c_busy));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] p);
        dv = 1'b1; prod = p; step();
        dv = 1'b0; step();
    endtask

    task automatic do_clear();
        clear = 1'b1; step();
        clear = 1'b0; step();
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step();
        vectors++; if (a_valid !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", a_valid); miscompares++; end
        vectors++; if (a_sum !== 20'h0) begin $display("FAIL reset_sum got %h exp 0", a_sum); miscompares++; end
        vectors++; if (a_cnt !== 8'd0) begin $display("FAIL reset_count got %0d exp 0", a_cnt); miscompares++; end
        vectors++; if ({a_ovf, a_drop, a_busy} !== 3'b000) begin $display("FAIL reset_flags got %b exp 000", {a_ovf, a_drop, a_busy}); miscompares++; end
        reset = 1'b0; step();
    endtask

    task automatic test_basic_sum();
        ready = 1'b1;
        pulse(16'd6); pulse(16'hFFFD); pulse(16'd100);
        dv = 1'b1; prod = 16'hC080; step();
        vectors++; if (a_valid !== 1'b1) begin $display("FAIL basic_valid got %b exp 1", a_valid); miscompares++; end
        vectors++; if (a_sum !== 20'hFC0E7) begin $display("FAIL basic_sum got %h exp fc0e7", a_sum); miscompares++; end
        vectors++; if (a_ovf !== 1'b0) begin $display("FAIL basic_ovf got %b exp 0", a_ovf); miscompares++; end
        vectors++; if (c_valid !== 1'b1 || c_sum !== 20'hFC080) begin $display("FAIL single_term got %b/%h exp 1/fc080", c_valid, c_sum); miscompares++; end
        dv = 1'b0; step();
        vectors++; if (a_valid !== 1'b0) begin $display("FAIL basic_one_cycle got %b exp 0", a_valid); miscompares++; end
        vectors++; if (a_cnt !== 8'd0) begin $display("FAIL basic_count_return got %0d exp 0", a_cnt); miscompares++; end
    endtask

    task automatic test_held_level();
        dv = 1'b1; prod = 16'd7;
        repeat (5) step();
        vectors++; if (a_cnt !== 8'd1) begin $display("FAIL held_level_count got %0d exp 1", a_cnt); miscompares++; end
        dv = 1'b0; step();
        do_clear();
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        pulse(16'd1); pulse(16'd1); pulse(16'd1);
        dv = 1'b1; prod = 16'd1; step();
        vectors++; if (a_valid !== 1'b1 || a_sum !== 20'd4) begin $display("FAIL bp_first_sum got %b/%h exp 1/4", a_valid, a_sum); miscompares++; end
        dv = 1'b0; step();
        pulse(16'd5); pulse(16'd9);
        vectors++; if (a_drop !== 1'b1 || a_busy !== 1'b1) begin $display("FAIL bp_drop_busy got %b/%b exp 1/1", a_drop, a_busy); miscompares++; end
        vectors++; if (a_valid !== 1'b1 || a_sum !== 20'd4) begin $display("FAIL bp_held got %b/%h exp 1/4", a_valid, a_sum); miscompares++; end
        ready = 1'b1; step();
        vectors++; if (a_valid !== 1'b0 || a_cnt !== 8'd0) begin $display("FAIL bp_handshake got %b/%0d exp 0/0", a_valid, a_cnt); miscompares++; end
        step();
        vectors++; if (a_cnt !== 8'd1) begin $display("FAIL bp_pending_consumed got %0d exp 1", a_cnt); miscompares++; end
        pulse(16'd1); pulse(16'd1);
        dv = 1'b1; prod = 16'd1; step();
        vectors++; if (a_valid !== 1'b1 || a_sum !== 20'd8) begin $display("FAIL bp_second_sum got %b/%h exp 1/8", a_valid, a_sum); miscompares++; end
        dv = 1'b0; step();
        vectors++; if (a_drop !== 1'b1) begin $display("FAIL bp_drop_sticky got %b exp 1", a_drop); miscompares++; end
        do_clear();
    endtask

    task automatic test_overflow();
        ready = 1'b1;
        pulse(16'h4000); pulse(16'h4000); pulse(16'h4000);
        dv = 1'b1; prod = 16'h4000; step();
        vectors++; if (b_valid !== 1'b1 || b_sum !== 16'h0000 || b_ovf !== 1'b1) begin $display("FAIL ovf16 got %b/%h/%b exp 1/0000/1", b_valid, b_sum, b_ovf); miscompares++; end
        vectors++; if (a_sum !== 20'h10000 || a_ovf !== 1'b0) begin $display("FAIL ovf20 got %h/%b exp 10000/0", a_sum, a_ovf); miscompares++; end
        dv = 1'b0; step();
        pulse(16'd1); pulse(16'd1); pulse(16'd1);
        dv = 1'b1; prod = 16'd1; step();
        vectors++; if (b_valid !== 1'b1 || b_sum !== 16'd4 || b_ovf !== 1'b0) begin $display("FAIL ovf16_next got %b/%h/%b exp 1/0004/0", b_valid, b_sum, b_ovf); miscompares++; end
        dv = 1'b0; step();
    endtask

    task automatic test_clear();
        ready = 1'b1;
        pulse(16'd1); pulse(16'd1);
        vectors++; if (a_cnt !== 8'd2) begin $display("FAIL clear_pre_count got %0d exp 2", a_cnt); miscompares++; end
        do_clear();
        vectors++; if (a_cnt !== 8'd0 || a_busy !== 1'b0) begin $display("FAIL clear_partial got %0d/%b exp 0/0", a_cnt, a_busy); miscompares++; end
        pulse(16'd1); pulse(16'd1); pulse(16'd1);
        dv = 1'b1; prod = 16'd1; step();
        vectors++; if (a_valid !== 1'b1 || a_sum !== 20'd4) begin $display("FAIL clear_after_sum got %b/%h exp 1/4", a_valid, a_sum); miscompares++; end
        dv = 1'b0; step();
        ready = 1'b0;
        pulse(16'd2); pulse(16'd2); pulse(16'd2); pulse(16'd2);
        pulse(16'd5); pulse(16'd9);
        clear = 1'b1; step(); clear = 1'b0;
        vectors++; if (a_valid !== 1'b0 || a_drop !== 1'b0 || a_busy !== 1'b0) begin $display("FAIL clear_output got %b/%b/%b exp 0/0/0", a_valid, a_drop, a_busy); miscompares++; end
        vectors++; if (a_sum !== 20'd8) begin $display("FAIL clear_keeps_sum got %h exp 8", a_sum); miscompares++; end
        ready = 1'b1; step();
    endtask

    task automatic test_reset_high_level();
        dv = 1'b1; prod = 16'd3; reset = 1'b1; step(); step();
        reset = 1'b0;
        repeat (4) step();
        vectors++; if (a_cnt !== 8'd0 || a_busy !== 1'b0) begin $display("FAIL reset_level_no_capture got %0d/%b exp 0/0", a_cnt, a_busy); miscompares++; end
        dv = 1'b0; step();
        dv = 1'b1; step();
        vectors++; if (a_cnt !== 8'd1) begin $display("FAIL reset_level_recapture got %0d exp 1", a_cnt); miscompares++; end
        dv = 1'b0; step();
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_held_level();
        test_backpressure();
        test_overflow();
        test_clear();
        test_reset_high_level();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
